// File: rtl/clock_divider_multi.sv
// clock_divider_multi: NUM_CH independent programmable dividers, each giving a square wave and a tick.
// Divisor writes are held in a shadow register until the period boundary, sync or disable.
module clock_divider_multi #(
   parameter int NUM_CH  = 4,
   parameter int CNT_W   = 25,
   parameter int DEF_DIV = 12_500_000
) (
   input  logic              clk_in,
   input  logic              rst_n,
   input  logic [NUM_CH-1:0] en,
   input  logic              sync,
   input  logic              wr_en,
   input  logic [2:0]        wr_ch,
   input  logic [CNT_W-1:0]  wr_div,
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] div_pend
);
   localparam logic [CNT_W-1:0] DEF = CNT_W'(DEF_DIV);
   logic [CNT_W-1:0] wr_val;
   assign wr_val = (wr_div < CNT_W'(2)) ? CNT_W'(2) : wr_div;
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [CNT_W-1:0] cnt_q, cnt_d, act_q, act_d, shd_q, shd_d;
      logic             pend_q, pend_d, clk_q, clk_d, tick_q, tick_d;
      logic             wr_hit, bnd, mid, clr, apply;
      assign wr_hit = wr_en && (wr_ch == 3'(i));
      assign bnd    = cnt_q == act_q - CNT_W'(1);
      assign mid    = cnt_q == (act_q >> 1) - CNT_W'(1);
      assign clr    = !en[i] || sync;
      // shd always equals act when nothing is pending, so applying shd is safe at any load point
      assign apply  = clr || bnd;
      always_comb begin
         shd_d  = wr_hit ? wr_val : shd_q;
         act_d  = apply ? shd_d : act_q;
         pend_d = !apply && (pend_q || wr_hit);
         cnt_d  = apply ? '0 : cnt_q + CNT_W'(1);
         clk_d  = clr ? 1'b0 : (bnd || mid) ? !clk_q : clk_q;
         tick_d = !clr && bnd;
      end
      always_ff @(posedge clk_in or negedge rst_n) begin
         if (!rst_n) begin
            cnt_q  <= '0;
            act_q  <= DEF;
            shd_q  <= DEF;
            pend_q <= 1'b0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
         end else begin
            cnt_q  <= cnt_d;
            act_q  <= act_d;
            shd_q  <= shd_d;
            pend_q <= pend_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
         end
      end
      assign clk_out[i]  = clk_q;
      assign tick[i]     = tick_q;
      assign div_pend[i] = pend_q;
   end
endmodule

// File: tb/tb_clock_divider_multi.sv
// tb_clock_divider_multi: directed checks of the two-channel divider with DEF_DIV=8.
module tb_clock_divider_multi;
   localparam int NC = 2;
   localparam int W  = 8;
   logic          clk_in = 1'b0;
   logic          rst_n  = 1'b0;
   logic          sync   = 1'b0;
   logic          wr_en  = 1'b0;
   logic [NC-1:0] en     = '1;
   logic [2:0]    wr_ch  = '0;
   logic [W-1:0]  wr_div = '0;
   logic [NC-1:0] clk_out, tick, div_pend;
   int errors = 0;
   int checks = 0;

   clock_divider_multi #(.NUM_CH(NC), .CNT_W(W), .DEF_DIV(8)) dut (
      .clk_in(clk_in), .rst_n(rst_n), .en(en), .sync(sync),
      .wr_en(wr_en), .wr_ch(wr_ch), .wr_div(wr_div),
      .clk_out(clk_out), .tick(tick), .div_pend(div_pend)
   );

   always #5 clk_in = ~clk_in;

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic chk(input string tag, input logic [NC-1:0] ec, input logic [NC-1:0] et, input logic [NC-1:0] ep);
      checks++;
      assert (clk_out === ec) else begin
         errors++;
         $error("FAIL %s clk_out=%b expected %b", tag, clk_out, ec);
      end
      checks++;
      assert (tick === et) else begin
         errors++;
         $error("FAIL %s tick=%b expected %b", tag, tick, et);
      end
      checks++;
      assert (div_pend === ep) else begin
         errors++;
         $error("FAIL %s div_pend=%b expected %b", tag, div_pend, ep);
      end
   endtask

   // t edges after a clean period start with the output low
   function automatic logic sq(input int t, input int d);
      return (t % d) >= (d / 2);
   endfunction

   function automatic logic tk(input int t, input int d);
      return (t % d) == 0;
   endfunction

   initial begin
      logic c0, t0, p0;
      repeat (3) begin
         step();
         chk("reset_hold", 2'b00, 2'b00, 2'b00);
      end
      rst_n = 1'b1;
      for (int n = 1; n <= 16; n++) begin
         step();
         chk("def_div8", {2{sq(n, 8)}}, {2{tk(n, 8)}}, 2'b00);
      end
      // div 5 written to ch0 at cnt=2, lands at the edge-24 boundary
      for (int n = 17; n <= 34; n++) begin
         if (n == 19) begin
            wr_en = 1'b1; wr_ch = 3'd0; wr_div = 8'd5;
         end
         step();
         wr_en = 1'b0;
         c0 = (n <= 24) ? sq(n, 8) : sq(n - 24, 5);
         t0 = (n <= 24) ? tk(n, 8) : tk(n - 24, 5);
         p0 = (n >= 19) && (n < 24);
         chk("div5", {sq(n, 8), c0}, {tk(n, 8), t0}, {1'b0, p0});
      end
      // divisor 0 then 1 both clamp to 2; then a write to a nonexistent channel
      for (int n = 35; n <= 55; n++) begin
         if (n == 35) begin
            wr_en = 1'b1; wr_ch = 3'd0; wr_div = 8'd0;
         end
         if (n == 46) begin
            wr_en = 1'b1; wr_ch = 3'd0; wr_div = 8'd1;
         end
         if (n == 52) begin
            wr_en = 1'b1; wr_ch = 3'd5; wr_div = 8'd3;
         end
         step();
         wr_en = 1'b0;
         c0 = (n <= 39) ? sq(n - 24, 5) : sq(n - 39, 2);
         t0 = (n <= 39) ? tk(n - 24, 5) : tk(n - 39, 2);
         p0 = (n >= 35 && n <= 38) || n == 46;
         chk(n < 52 ? "clamp2" : "bad_ch", {sq(n, 8), c0}, {tk(n, 8), t0}, {1'b0, p0});
      end
      wr_en = 1'b1; wr_ch = 3'd0; wr_div = 8'd6;
      step();
      wr_ch = 3'd1; wr_div = 8'd9;
      step();
      wr_en = 1'b0;
      checks++;
      assert (div_pend === 2'b10) else begin
         errors++;
         $error("FAIL pend_69 div_pend=%b expected %b", div_pend, 2'b10);
      end
      repeat (13) step();
      sync = 1'b1;
      step();
      sync = 1'b0;
      chk("sync", 2'b00, 2'b00, 2'b00);
      // in phase at 6 and 9; then ch0 disabled with a pending write of 4
      for (int j = 1; j <= 35; j++) begin
         if (j == 22) begin
            wr_en = 1'b1; wr_ch = 3'd0; wr_div = 8'd4;
         end
         if (j == 23) en = 2'b10;
         if (j == 26) en = 2'b11;
         step();
         wr_en = 1'b0;
         c0 = (j <= 22) ? sq(j, 6) : (j <= 25) ? 1'b0 : sq(j - 25, 4);
         t0 = (j <= 22) ? tk(j, 6) : (j <= 25) ? 1'b0 : tk(j - 25, 4);
         p0 = j == 22;
         chk(j <= 22 ? "sync_6_9" : "disable", {sq(j, 9), c0}, {tk(j, 9), t0}, {1'b0, p0});
      end
      #2 rst_n = 1'b0;
      #1 chk("async_rst", 2'b00, 2'b00, 2'b00);
      #1 rst_n = 1'b1;
      for (int n = 1; n <= 8; n++) begin
         step();
         chk("after_rst", {2{sq(n, 8)}}, {2{tk(n, 8)}}, 2'b00);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
